// File: rtl/axi_sbus_bridge.sv
// AXI4 slave to req/gnt/rvalid simple-bus bridge. One bus access is in flight at a time,
// INCR bursts are split into word accesses, and a bus err is reported as SLVERR.
//
// state   | meaning
// IDLE    | waiting for AW or AR, round robin when both are valid
// WR_DATA | waiting for the next W beat
// WR_REQ  | write access requested, waiting for gnt
// WR_WAIT | write granted, waiting for rvalid
// WR_RESP | B response presented until BREADY
// RD_REQ  | read access requested, waiting for gnt
// RD_WAIT | read granted, waiting for rvalid
// RD_RESP | R beat presented and held until RREADY
module axi_sbus_bridge #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] S_AXI_AWADDR,
    input  logic [7:0]        S_AXI_AWLEN,
    input  logic              S_AXI_AWVALID,
    output logic              S_AXI_AWREADY,
    input  logic [31:0]       S_AXI_WDATA,
    input  logic [3:0]        S_AXI_WSTRB,
    input  logic              S_AXI_WVALID,
    output logic              S_AXI_WREADY,
    output logic [1:0]        S_AXI_BRESP,
    output logic              S_AXI_BVALID,
    input  logic              S_AXI_BREADY,
    input  logic [ADDR_W-1:0] S_AXI_ARADDR,
    input  logic [7:0]        S_AXI_ARLEN,
    input  logic              S_AXI_ARVALID,
    output logic              S_AXI_ARREADY,
    output logic [31:0]       S_AXI_RDATA,
    output logic [1:0]        S_AXI_RRESP,
    output logic              S_AXI_RLAST,
    output logic              S_AXI_RVALID,
    input  logic              S_AXI_RREADY,
    output logic              req,
    output logic [ADDR_W-1:0] addr,
    output logic              we,
    output logic [3:0]        be,
    output logic [31:0]       wdata,
    input  logic [31:0]       rdata,
    input  logic              gnt,
    input  logic              rvalid,
    input  logic              err
);

    typedef enum logic [2:0] {
        IDLE, WR_DATA, WR_REQ, WR_WAIT, WR_RESP, RD_REQ, RD_WAIT, RD_RESP
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr_q, addr_nxt;
    logic [7:0]        len_q, len_nxt;
    logic [7:0]        cnt_q, cnt_nxt;
    logic              err_acc, err_acc_nxt;
    logic              last_rd, last_rd_nxt;
    logic              we_q, we_nxt;
    logic [3:0]        be_q, be_nxt;
    logic [31:0]       wdata_q, wdata_nxt;
    logic [31:0]       rdata_q, rdata_nxt;
    logic [1:0]        rresp_q, rresp_nxt;
    logic              rlast_q, rlast_nxt;
    logic              grant_w, grant_r;

    // last_rd steers the tie-break: write wins after a read (and after reset)
    assign grant_w = S_AXI_AWVALID && (!S_AXI_ARVALID || last_rd);
    assign grant_r = S_AXI_ARVALID && (!S_AXI_AWVALID || !last_rd);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            addr_q  <= '0;
            len_q   <= '0;
            cnt_q   <= '0;
            err_acc <= 1'b0;
            last_rd <= 1'b1;
            we_q    <= 1'b0;
            be_q    <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            rresp_q <= 2'b00;
            rlast_q <= 1'b0;
        end else begin
            state   <= state_nxt;
            addr_q  <= addr_nxt;
            len_q   <= len_nxt;
            cnt_q   <= cnt_nxt;
            err_acc <= err_acc_nxt;
            last_rd <= last_rd_nxt;
            we_q    <= we_nxt;
            be_q    <= be_nxt;
            wdata_q <= wdata_nxt;
            rdata_q <= rdata_nxt;
            rresp_q <= rresp_nxt;
            rlast_q <= rlast_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        addr_nxt    = addr_q;
        len_nxt     = len_q;
        cnt_nxt     = cnt_q;
        err_acc_nxt = err_acc;
        last_rd_nxt = last_rd;
        we_nxt      = we_q;
        be_nxt      = be_q;
        wdata_nxt   = wdata_q;
        rdata_nxt   = rdata_q;
        rresp_nxt   = rresp_q;
        rlast_nxt   = rlast_q;
        case (state)
            IDLE: begin
                if (grant_w) begin
                    addr_nxt    = S_AXI_AWADDR;
                    len_nxt     = S_AXI_AWLEN;
                    cnt_nxt     = '0;
                    err_acc_nxt = 1'b0;
                    state_nxt   = WR_DATA;
                end else if (grant_r) begin
                    addr_nxt    = S_AXI_ARADDR;
                    len_nxt     = S_AXI_ARLEN;
                    cnt_nxt     = '0;
                    we_nxt      = 1'b0;
                    be_nxt      = 4'hF;
                    state_nxt   = RD_REQ;
                end
            end
            WR_DATA: begin
                if (S_AXI_WVALID) begin
                    we_nxt    = 1'b1;
                    be_nxt    = S_AXI_WSTRB;
                    wdata_nxt = S_AXI_WDATA;
                    state_nxt = WR_REQ;
                end
            end
            WR_REQ: begin
                if (gnt) state_nxt = WR_WAIT;
            end
            WR_WAIT: begin
                if (rvalid) begin
                    err_acc_nxt = err_acc | err;
                    if (cnt_q != len_q) begin
                        cnt_nxt   = cnt_q + 8'd1;
                        addr_nxt  = addr_q + ADDR_W'(4);
                        state_nxt = WR_DATA;
                    end else begin
                        state_nxt = WR_RESP;
                    end
                end
            end
            WR_RESP: begin
                if (S_AXI_BREADY) begin
                    last_rd_nxt = 1'b0;
                    state_nxt   = IDLE;
                end
            end
            RD_REQ: begin
                if (gnt) state_nxt = RD_WAIT;
            end
            RD_WAIT: begin
                if (rvalid) begin
                    rdata_nxt = rdata;
                    rresp_nxt = err ? 2'b10 : 2'b00;
                    rlast_nxt = (cnt_q == len_q);
                    state_nxt = RD_RESP;
                end
            end
            RD_RESP: begin
                if (S_AXI_RREADY) begin
                    rlast_nxt = 1'b0;
                    if (rlast_q) begin
                        last_rd_nxt = 1'b1;
                        state_nxt   = IDLE;
                    end else begin
                        cnt_nxt   = cnt_q + 8'd1;
                        addr_nxt  = addr_q + ADDR_W'(4);
                        state_nxt = RD_REQ;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign S_AXI_AWREADY = (state == IDLE) && grant_w;
    assign S_AXI_ARREADY = (state == IDLE) && grant_r;
    assign S_AXI_WREADY  = (state == WR_DATA);
    assign S_AXI_BVALID  = (state == WR_RESP);
    assign S_AXI_BRESP   = ((state == WR_RESP) && err_acc) ? 2'b10 : 2'b00;
    assign S_AXI_RVALID  = (state == RD_RESP);
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;
    assign S_AXI_RLAST   = rlast_q;
    assign req           = (state == WR_REQ) || (state == RD_REQ);
    assign addr          = addr_q;
    assign we            = we_q;
    assign be            = be_q;
    assign wdata         = wdata_q;

endmodule

// File: tb/tb_axi_sbus_bridge.sv
// Self-checking bench for axi_sbus_bridge: scoreboarded bus accesses and AXI responses,
// plus per-scenario inline checks.
module tb_axi_sbus_bridge;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] S_AXI_AWADDR = '0;
    logic [7:0]  S_AXI_AWLEN = '0;
    logic        S_AXI_AWVALID = 1'b0;
    logic        S_AXI_AWREADY;
    logic [31:0] S_AXI_WDATA = '0;
    logic [3:0]  S_AXI_WSTRB = '0;
    logic        S_AXI_WVALID = 1'b0;
    logic        S_AXI_WREADY;
    logic [1:0]  S_AXI_BRESP;
    logic        S_AXI_BVALID;
    logic        S_AXI_BREADY = 1'b0;
    logic [31:0] S_AXI_ARADDR = '0;
    logic [7:0]  S_AXI_ARLEN = '0;
    logic        S_AXI_ARVALID = 1'b0;
    logic        S_AXI_ARREADY;
    logic [31:0] S_AXI_RDATA;
    logic [1:0]  S_AXI_RRESP;
    logic        S_AXI_RLAST;
    logic        S_AXI_RVALID;
    logic        S_AXI_RREADY = 1'b0;
    logic        req;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        gnt;
    logic        rvalid;
    logic        err;

    int vectors = 0;
    int miscompares = 0;
    int cyc_cnt = 0;

    typedef struct { logic [31:0] a; logic w; logic [3:0] b; logic [31:0] d; } bus_t;
    typedef struct { logic [31:0] d; logic [1:0] resp; logic last; } rbeat_t;
    bus_t        exp_bus[$];
    rbeat_t      exp_r[$];
    logic [1:0]  exp_b[$];

    // bus responder state
    logic        bus_gnt = 1'b0;
    logic        bus_rvalid = 1'b0;
    logic        bus_err = 1'b0;
    logic [31:0] bus_rdata = '0;
    int          req_cycles = 0;
    logic [31:0] first_addr = '0;
    logic [3:0]  first_be = '0;
    logic [31:0] hs_addr = '0;
    int          gnt_delay = 1;
    bit          hold_rsp = 1'b0;
    bit          force_rvalid = 1'b0;
    logic [31:0] err_addr = 32'hFFFF_FFF1;
    bus_t        rsp_e;
    rbeat_t      mon_r;
    logic [1:0]  mon_b;

    assign gnt    = bus_gnt;
    assign rvalid = bus_rvalid | force_rvalid;
    assign err    = bus_err;
    assign rdata  = bus_rdata;

    axi_sbus_bridge #(.ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWLEN(S_AXI_AWLEN),
        .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
        .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
        .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARLEN(S_AXI_ARLEN),
        .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
        .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RLAST(S_AXI_RLAST),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .req(req), .addr(addr), .we(we), .be(be), .wdata(wdata),
        .rdata(rdata), .gnt(gnt), .rvalid(rvalid), .err(err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    function automatic logic [31:0] mem_val(input logic [31:0] a);
        logic [7:0] lo;
        lo = 8'hA0 + a[9:2];
        return {a[31:16], 8'h00, lo};
    endfunction

    function automatic void push_bus(input logic [31:0] a, input logic w, input logic [3:0] b,
                                     input logic [31:0] d);
        bus_t e;
        e.a = a; e.w = w; e.b = b; e.d = d;
        exp_bus.push_back(e);
    endfunction

    function automatic void push_r(input logic [31:0] d, input logic [1:0] resp, input logic last);
        rbeat_t e;
        e.d = d; e.resp = resp; e.last = last;
        exp_r.push_back(e);
    endfunction

    // Bus slave: gnt after gnt_delay request cycles, rvalid the cycle after the grant.
    always @(negedge clk) begin
        if (reset) begin
            bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0; req_cycles = 0;
        end else begin
            bus_rvalid = 1'b0;
            bus_err    = 1'b0;
            if (bus_gnt) begin
                bus_gnt    = 1'b0;
                req_cycles = 0;
                if (!hold_rsp) begin
                    bus_rvalid = 1'b1;
                    bus_err    = (hs_addr == err_addr);
                    bus_rdata  = mem_val(hs_addr);
                end
            end else if (req) begin
                if (req_cycles == 0) begin
                    first_addr = addr;
                    first_be   = be;
                end else begin
                    vectors++;
                    if (addr !== first_addr || be !== first_be) begin
                        miscompares++;
                        $display("FAIL req_hold: addr=%h be=%h while waiting, required addr=%h be=%h",
                                 addr, be, first_addr, first_be);
                    end
                end
                if (req_cycles == gnt_delay) begin
                    bus_gnt = 1'b1;
                    hs_addr = addr;
                    vectors++;
                    if (exp_bus.size() == 0) begin
                        miscompares++;
                        $display("FAIL bus_access: unexpected access addr=%h we=%b", addr, we);
                    end else begin
                        rsp_e = exp_bus.pop_front();
                        if (addr !== rsp_e.a || we !== rsp_e.w || be !== rsp_e.b ||
                            (rsp_e.w && wdata !== rsp_e.d)) begin
                            miscompares++;
                            $display("FAIL bus_access: got addr=%h we=%b be=%h wdata=%h, required addr=%h we=%b be=%h wdata=%h",
                                     addr, we, be, wdata, rsp_e.a, rsp_e.w, rsp_e.b, rsp_e.d);
                        end
                    end
                end
                req_cycles++;
            end else begin
                req_cycles = 0;
            end
        end
    end

    // AXI response monitor, sampled just before the active edge
    always @(negedge clk) begin
        #4;
        if (!reset && S_AXI_RVALID && S_AXI_RREADY) begin
            vectors++;
            if (exp_r.size() == 0) begin
                miscompares++;
                $display("FAIL r_beat: unexpected beat data=%h", S_AXI_RDATA);
            end else begin
                mon_r = exp_r.pop_front();
                if (S_AXI_RDATA !== mon_r.d || S_AXI_RRESP !== mon_r.resp || S_AXI_RLAST !== mon_r.last) begin
                    miscompares++;
                    $display("FAIL r_beat: got data=%h resp=%b last=%b, required data=%h resp=%b last=%b",
                             S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, mon_r.d, mon_r.resp, mon_r.last);
                end
            end
        end
        if (!reset && S_AXI_BVALID && S_AXI_BREADY) begin
            vectors++;
            if (exp_b.size() == 0) begin
                miscompares++;
                $display("FAIL b_resp: unexpected response %b", S_AXI_BRESP);
            end else begin
                mon_b = exp_b.pop_front();
                if (S_AXI_BRESP !== mon_b) begin
                    miscompares++;
                    $display("FAIL b_resp: got %b, required %b", S_AXI_BRESP, mon_b);
                end
            end
        end
    end

    task automatic wait_cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic aw_hs(input logic [31:0] a, input logic [7:0] len, output int t0);
        bit ok = 1'b0;
        t0 = 0;
        S_AXI_AWADDR = a; S_AXI_AWLEN = len; S_AXI_AWVALID = 1'b1;
        for (int n = 0; n <= 60 && !ok; n++) begin
            #1;
            if (S_AXI_AWREADY) begin ok = 1'b1; t0 = cyc_cnt; end
            wait_cyc();
        end
        S_AXI_AWVALID = 1'b0;
        if (!ok) begin
            vectors++; miscompares++;
            $display("FAIL aw_handshake: AWREADY=0 after 60 cycles, required 1 (addr %h)", a);
        end
    endtask

    task automatic ar_hs(input logic [31:0] a, input logic [7:0] len, output int t0);
        bit ok = 1'b0;
        t0 = 0;
        S_AXI_ARADDR = a; S_AXI_ARLEN = len; S_AXI_ARVALID = 1'b1;
        for (int n = 0; n <= 60 && !ok; n++) begin
            #1;
            if (S_AXI_ARREADY) begin ok = 1'b1; t0 = cyc_cnt; end
            wait_cyc();
        end
        S_AXI_ARVALID = 1'b0;
        if (!ok) begin
            vectors++; miscompares++;
            $display("FAIL ar_handshake: ARREADY=0 after 60 cycles, required 1 (addr %h)", a);
        end
    endtask

    task automatic w_beat(input logic [31:0] d, input logic [3:0] strb);
        bit ok = 1'b0;
        S_AXI_WDATA = d; S_AXI_WSTRB = strb; S_AXI_WVALID = 1'b1;
        for (int n = 0; n <= 60 && !ok; n++) begin
            #1;
            if (S_AXI_WREADY) ok = 1'b1;
            wait_cyc();
        end
        S_AXI_WVALID = 1'b0;
        if (!ok) begin
            vectors++; miscompares++;
            $display("FAIL w_handshake: WREADY=0 after 60 cycles, required 1");
        end
    endtask

    task automatic b_take(output int t);
        bit ok = 1'b0;
        t = 0;
        S_AXI_BREADY = 1'b1;
        for (int n = 0; n <= 60 && !ok; n++) begin
            #1;
            if (S_AXI_BVALID) begin ok = 1'b1; t = cyc_cnt; end
            wait_cyc();
        end
        S_AXI_BREADY = 1'b0;
        if (!ok) begin
            vectors++; miscompares++;
            $display("FAIL b_handshake: BVALID=0 after 60 cycles, required 1");
        end
    endtask

    task automatic r_take(output int t);
        bit ok = 1'b0;
        t = 0;
        S_AXI_RREADY = 1'b1;
        for (int n = 0; n <= 60 && !ok; n++) begin
            #1;
            if (S_AXI_RVALID) begin ok = 1'b1; t = cyc_cnt; end
            wait_cyc();
        end
        S_AXI_RREADY = 1'b0;
        if (!ok) begin
            vectors++; miscompares++;
            $display("FAIL r_handshake: RVALID=0 after 60 cycles, required 1");
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) wait_cyc();
        vectors++;
        if ({S_AXI_AWREADY, S_AXI_ARREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_RVALID,
             S_AXI_RLAST, req, we} !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_ctrl: ready/valid/req/we/rlast=%b, required 00000000",
                     {S_AXI_AWREADY, S_AXI_ARREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_RVALID,
                      S_AXI_RLAST, req, we});
        end
        vectors++;
        if (addr !== 32'h0 || be !== 4'h0 || wdata !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_bus: addr=%h be=%h wdata=%h, required 0", addr, be, wdata);
        end
        vectors++;
        if (S_AXI_RDATA !== 32'h0 || S_AXI_BRESP !== 2'b00 || S_AXI_RRESP !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_resp: rdata=%h bresp=%b rresp=%b, required 0", S_AXI_RDATA,
                     S_AXI_BRESP, S_AXI_RRESP);
        end
        reset = 1'b0;
        wait_cyc();
    endtask

    task automatic test_arbitration();
        int t;
        push_bus(32'h0000_0100, 1'b1, 4'hF, 32'h1111_0001); exp_b.push_back(2'b00);
        push_bus(32'h0000_0200, 1'b0, 4'hF, 32'h0);         push_r(mem_val(32'h200), 2'b00, 1'b1);
        push_bus(32'h0000_0300, 1'b1, 4'h3, 32'h3333_0003); exp_b.push_back(2'b00);
        S_AXI_ARADDR = 32'h200; S_AXI_ARLEN = 8'd0; S_AXI_ARVALID = 1'b1;
        S_AXI_AWADDR = 32'h100; S_AXI_AWLEN = 8'd0; S_AXI_AWVALID = 1'b1;
        #1;
        vectors++;
        if (S_AXI_AWREADY !== 1'b1 || S_AXI_ARREADY !== 1'b0) begin
            miscompares++;
            $display("FAIL arb_first: awready=%b arready=%b, required 1 0", S_AXI_AWREADY, S_AXI_ARREADY);
        end
        aw_hs(32'h100, 8'd0, t);
        w_beat(32'h1111_0001, 4'hF);
        S_AXI_AWADDR = 32'h300; S_AXI_AWLEN = 8'd0; S_AXI_AWVALID = 1'b1;
        b_take(t);
        #1;
        vectors++;
        if (S_AXI_AWREADY !== 1'b0 || S_AXI_ARREADY !== 1'b1) begin
            miscompares++;
            $display("FAIL arb_second: awready=%b arready=%b, required 0 1", S_AXI_AWREADY, S_AXI_ARREADY);
        end
        ar_hs(32'h200, 8'd0, t);
        r_take(t);
        aw_hs(32'h300, 8'd0, t);
        w_beat(32'h3333_0003, 4'h3);
        b_take(t);
    endtask

    task automatic test_single_write();
        int t0, tb;
        push_bus(32'h9a10_0008, 1'b1, 4'b0001, 32'h0000_0041);
        exp_b.push_back(2'b00);
        aw_hs(32'h9a10_0008, 8'd0, t0);
        w_beat(32'h0000_0041, 4'b0001);
        b_take(tb);
        vectors++;
        if (tb - t0 - 1 != 4) begin
            miscompares++;
            $display("FAIL write_latency: %0d cycles, required 4", tb - t0 - 1);
        end
    endtask

    task automatic test_read_burst();
        int t0, tr;
        for (int i = 0; i < 4; i++) begin
            push_bus(32'h1000 + 32'(4 * i), 1'b0, 4'hF, 32'h0);
            push_r(32'hA0 + 32'(i), 2'b00, i == 3);
        end
        ar_hs(32'h1000, 8'd3, t0);
        r_take(tr);
        vectors++;
        if (tr - t0 - 1 != 3) begin
            miscompares++;
            $display("FAIL read_latency: %0d cycles, required 3", tr - t0 - 1);
        end
        for (int i = 1; i < 4; i++) r_take(tr);
    endtask

    task automatic test_errors();
        int t;
        err_addr = 32'h504;
        push_bus(32'h500, 1'b1, 4'hF, 32'h5500_0000);
        push_bus(32'h504, 1'b1, 4'hC, 32'h5500_0001);
        exp_b.push_back(2'b10);
        aw_hs(32'h500, 8'd1, t);
        w_beat(32'h5500_0000, 4'hF);
        w_beat(32'h5500_0001, 4'hC);
        b_take(t);
        err_addr = 32'h600;
        push_bus(32'h600, 1'b0, 4'hF, 32'h0); push_r(mem_val(32'h600), 2'b10, 1'b0);
        push_bus(32'h604, 1'b0, 4'hF, 32'h0); push_r(mem_val(32'h604), 2'b00, 1'b1);
        ar_hs(32'h600, 8'd1, t);
        r_take(t);
        r_take(t);
        err_addr = 32'hFFFF_FFF1;
    endtask

    task automatic test_rready_stall();
        int t;
        bit got = 1'b0;
        push_bus(32'h3000, 1'b0, 4'hF, 32'h0); push_r(mem_val(32'h3000), 2'b00, 1'b0);
        push_bus(32'h3004, 1'b0, 4'hF, 32'h0); push_r(mem_val(32'h3004), 2'b00, 1'b1);
        ar_hs(32'h3000, 8'd1, t);
        for (int n = 0; n <= 60 && !got; n++) begin
            #1;
            if (S_AXI_RVALID) got = 1'b1;
            else wait_cyc();
        end
        if (!got) begin
            vectors++; miscompares++;
            $display("FAIL stall_rvalid: RVALID=0 after 60 cycles, required 1");
        end
        for (int k = 0; k < 5; k++) begin
            wait_cyc();
            #1;
            vectors++;
            if (S_AXI_RVALID !== 1'b1 || S_AXI_RDATA !== mem_val(32'h3000) || S_AXI_RLAST !== 1'b0 ||
                req !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_hold: rvalid=%b rdata=%h rlast=%b req=%b, required 1 %h 0 0",
                         S_AXI_RVALID, S_AXI_RDATA, S_AXI_RLAST, req, mem_val(32'h3000));
            end
        end
        r_take(t);
        r_take(t);
    endtask

    task automatic test_gnt_delay();
        int t0, t1;
        gnt_delay = 3;
        push_bus(32'h4000, 1'b1, 4'h6, 32'h4444_0000); exp_b.push_back(2'b00);
        aw_hs(32'h4000, 8'd0, t0);
        w_beat(32'h4444_0000, 4'h6);
        b_take(t1);
        vectors++;
        if (t1 - t0 - 1 != 6) begin
            miscompares++;
            $display("FAIL gnt_delay_write: %0d cycles, required 6", t1 - t0 - 1);
        end
        push_bus(32'h4010, 1'b0, 4'hF, 32'h0); push_r(mem_val(32'h4010), 2'b00, 1'b1);
        ar_hs(32'h4010, 8'd0, t0);
        r_take(t1);
        vectors++;
        if (t1 - t0 - 1 != 5) begin
            miscompares++;
            $display("FAIL gnt_delay_read: %0d cycles, required 5", t1 - t0 - 1);
        end
        gnt_delay = 1;
    endtask

    task automatic test_wrap();
        int t;
        push_bus(32'hFFFF_FFF8, 1'b0, 4'hF, 32'h0); push_r(mem_val(32'hFFFF_FFF8), 2'b00, 1'b0);
        push_bus(32'hFFFF_FFFC, 1'b0, 4'hF, 32'h0); push_r(mem_val(32'hFFFF_FFFC), 2'b00, 1'b0);
        push_bus(32'h0000_0000, 1'b0, 4'hF, 32'h0); push_r(mem_val(32'h0000_0000), 2'b00, 1'b1);
        ar_hs(32'hFFFF_FFF8, 8'd2, t);
        for (int i = 0; i < 3; i++) r_take(t);
    endtask

    task automatic test_back_to_back();
        int t;
        for (int i = 0; i < 256; i++) begin
            push_bus(32'h8000 + 32'(4 * i), 1'b1, 4'(i) ^ 4'hA, 32'hC000_0000 + 32'(i));
        end
        exp_b.push_back(2'b00);
        aw_hs(32'h8000, 8'd255, t);
        for (int i = 0; i < 256; i++) w_beat(32'hC000_0000 + 32'(i), 4'(i) ^ 4'hA);
        b_take(t);
        for (int i = 0; i < 256; i++) begin
            push_bus(32'h8000 + 32'(4 * i), 1'b0, 4'hF, 32'h0);
            push_r(mem_val(32'h8000 + 32'(4 * i)), 2'b00, i == 255);
        end
        ar_hs(32'h8000, 8'd255, t);
        for (int i = 0; i < 256; i++) r_take(t);
    endtask

    task automatic test_reset_mid();
        int t;
        bit seen = 1'b0;
        bit done = 1'b0;
        hold_rsp = 1'b1;
        push_bus(32'h2000, 1'b0, 4'hF, 32'h0);
        ar_hs(32'h2000, 8'd0, t);
        for (int n = 0; n <= 60 && !done; n++) begin
            #1;
            if (req) seen = 1'b1;
            else if (seen) done = 1'b1;
            if (!done) wait_cyc();
        end
        if (!done) begin
            vectors++; miscompares++;
            $display("FAIL mid_wait: read never reached RD_WAIT within 60 cycles");
        end
        reset = 1'b1;
        #1;
        vectors++;
        if (req !== 1'b0 || addr !== 32'h0 || be !== 4'h0 || S_AXI_RVALID !== 1'b0 ||
            S_AXI_RDATA !== 32'h0 || S_AXI_ARREADY !== 1'b0) begin
            miscompares++;
            $display("FAIL mid_reset: req=%b addr=%h be=%h rvalid=%b rdata=%h arready=%b, required all 0",
                     req, addr, be, S_AXI_RVALID, S_AXI_RDATA, S_AXI_ARREADY);
        end
        wait_cyc();
        wait_cyc();
        reset = 1'b0;
        hold_rsp = 1'b0;
        wait_cyc();
        force_rvalid = 1'b1;
        wait_cyc();
        force_rvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            wait_cyc();
            vectors++;
            if (S_AXI_RVALID !== 1'b0 || req !== 1'b0 || S_AXI_BVALID !== 1'b0) begin
                miscompares++;
                $display("FAIL late_rvalid: rvalid=%b req=%b bvalid=%b, required 0 0 0",
                         S_AXI_RVALID, req, S_AXI_BVALID);
            end
        end
    endtask

    initial begin
        test_reset();
        test_arbitration();
        test_single_write();
        test_read_burst();
        test_errors();
        test_rready_stall();
        test_gnt_delay();
        test_wrap();
        test_back_to_back();
        test_reset_mid();
        repeat (3) wait_cyc();
        vectors++;
        if (exp_bus.size() != 0 || exp_r.size() != 0 || exp_b.size() != 0) begin
            miscompares++;
            $display("FAIL drain: pending bus=%0d r=%0d b=%0d, required 0 0 0",
                     exp_bus.size(), exp_r.size(), exp_b.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        miscompares++;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $fatal(1, "watchdog");
    end

endmodule
